// File: rtl/slurm16_cpu_pkg.sv
// slurm16_cpu_pkg: shared register-file constants, ALU slot type and register decode helpers.
package slurm16_cpu_pkg;
    localparam int REG_COUNT = 16;
    localparam int REG_SEL_BITS = $clog2(REG_COUNT);
    localparam int LOAD_DEPTH_DEFAULT = 4;

    typedef struct packed {
        logic valid;
        logic [REG_SEL_BITS-1:0] dest;
    } aluSlot_t;

    // Register 0 is hardwired to zero, so it never contributes a pending bit.
    function automatic logic [REG_COUNT-1:0] regOneHot(input logic [REG_SEL_BITS-1:0] sel);
        return (sel == '0) ? '0 : REG_COUNT'(1) << sel;
    endfunction

    function automatic logic srcMatch(input logic [REG_SEL_BITS-1:0] srcA, srcB, tag);
        return (tag != '0) && (srcA == tag || srcB == tag);
    endfunction
endpackage

// File: rtl/slurm16_load_tag_fifo.sv
// slurm16_load_tag_fifo: circular queue of outstanding load destination tags.
// Entries are exposed with per-entry valid bits for parallel hazard matching.
module slurm16_load_tag_fifo #(
    parameter int DEPTH = 4,
    parameter int TAG_BITS = 4
) (
    input  logic                               CLK,
    input  logic                               RST,
    input  logic                               push,
    input  logic [TAG_BITS-1:0]                pushTag,
    input  logic                               pop,
    output logic [DEPTH-1:0][TAG_BITS-1:0]     tags,
    output logic [DEPTH-1:0]                   valid,
    output logic [TAG_BITS-1:0]                headTag,
    output logic [$clog2(DEPTH):0]             count,
    output logic                               full,
    output logic                               empty
);
    localparam int PTR_BITS = $clog2(DEPTH);

    logic [PTR_BITS-1:0] head, tail;
    logic doPush, doPop;

    assign empty = count == '0;
    assign full = count == (PTR_BITS+1)'(DEPTH);
    assign doPop = pop && !empty;
    // A full queue still takes a push when the head leaves in the same cycle.
    assign doPush = push && (!full || doPop);
    assign headTag = tags[head];

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            head <= '0;
            tail <= '0;
            count <= '0;
            valid <= '0;
            tags <= '0;
        end else begin
            if (doPop) begin
                valid[head] <= 1'b0;
                head <= head + 1'b1;
            end
            // Push comes second so a full-queue push/pop on one slot leaves it valid.
            if (doPush) begin
                valid[tail] <= 1'b1;
                tags[tail] <= pushTag;
                tail <= tail + 1'b1;
            end
            count <= count + (PTR_BITS+1)'(doPush) - (PTR_BITS+1)'(doPop);
        end
    end
endmodule

// File: rtl/slurm16_cpu_scoreboard.sv
// slurm16_cpu_scoreboard: register scoreboard and issue interlock for the slurm16 pipeline.
// Define SLURM16_SCOREBOARD_FWD_EN when EX/MEM ALU results are bypassed to the operands.
module slurm16_cpu_scoreboard
    import slurm16_cpu_pkg::*;
#(
    parameter int REGISTER_BITS = 4,
    parameter int LOAD_DEPTH = LOAD_DEPTH_DEFAULT
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic                          issue_valid,
    input  logic [REGISTER_BITS-1:0]      regA_sel,
    input  logic [REGISTER_BITS-1:0]      regB_sel,
    input  logic                          dest_we,
    input  logic [REGISTER_BITS-1:0]      dest_sel,
    input  logic                          is_load,
    input  logic                          flush,
    input  logic                          mem_ack_valid,
    output logic                          stall,
    output logic [REG_COUNT-1:0]          pending,
    output logic [$clog2(LOAD_DEPTH):0]   load_count,
    output logic                          ack_underflow
);
    logic [LOAD_DEPTH-1:0][REGISTER_BITS-1:0] queueTags;
    logic [LOAD_DEPTH-1:0] queueValid;
    logic [REGISTER_BITS-1:0] headTag;
    logic queueFull, queueEmpty;
    logic srcHitQueue, wawHit, aluHit, loadFullHit;
    logic accept, aluAccept, loadPush, ackPop;
    logic [REG_COUNT-1:0] queueMask, nextQueueMask, nextPending;
    aluSlot_t exSlot, memSlot, nextEx, nextMem;

    slurm16_load_tag_fifo #(
        .DEPTH(LOAD_DEPTH),
        .TAG_BITS(REGISTER_BITS)
    ) loadQueue (
        .CLK(CLK),
        .RST(RST),
        .push(loadPush),
        .pushTag(dest_sel),
        .pop(mem_ack_valid),
        .tags(queueTags),
        .valid(queueValid),
        .headTag(headTag),
        .count(load_count),
        .full(queueFull),
        .empty(queueEmpty)
    );

    always_comb begin
        srcHitQueue = 1'b0;
        wawHit = 1'b0;
        queueMask = '0;
        for (int i = 0; i < LOAD_DEPTH; i++) begin
            srcHitQueue |= queueValid[i] && srcMatch(regA_sel, regB_sel, queueTags[i]);
            wawHit |= queueValid[i] && dest_we && srcMatch(dest_sel, dest_sel, queueTags[i]);
            queueMask |= queueValid[i] ? regOneHot(queueTags[i]) : '0;
        end
    end

`ifdef SLURM16_SCOREBOARD_FWD_EN
    assign aluHit = 1'b0;
`else
    assign aluHit = (exSlot.valid && srcMatch(regA_sel, regB_sel, exSlot.dest))
                 || (memSlot.valid && srcMatch(regA_sel, regB_sel, memSlot.dest));
`endif

    assign loadFullHit = is_load && queueFull && !mem_ack_valid;
    assign stall = issue_valid && (srcHitQueue || aluHit || wawHit || loadFullHit);
    assign accept = issue_valid && !stall && !flush;
    assign aluAccept = accept && dest_we && !is_load && dest_sel != '0;
    assign loadPush = accept && dest_we && is_load && dest_sel != '0;
    assign ackPop = mem_ack_valid && !queueEmpty;

    // Queue tags are unique (WAW stalls duplicates), so clearing the head bit is exact.
    assign nextQueueMask = (queueMask & ~(ackPop ? regOneHot(headTag) : '0))
                         | (loadPush ? regOneHot(dest_sel) : '0);
    assign nextEx = '{valid: aluAccept, dest: dest_sel};
    assign nextMem = '{valid: exSlot.valid && !flush, dest: exSlot.dest};
    assign nextPending = nextQueueMask
                       | (nextEx.valid ? regOneHot(nextEx.dest) : '0)
                       | (nextMem.valid ? regOneHot(nextMem.dest) : '0);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            exSlot <= '0;
            memSlot <= '0;
            pending <= '0;
            ack_underflow <= 1'b0;
        end else begin
            exSlot <= nextEx;
            memSlot <= nextMem;
            pending <= nextPending;
            ack_underflow <= ack_underflow || (mem_ack_valid && queueEmpty);
        end
    end
endmodule

// File: tb/tb_slurm16_cpu_scoreboard.sv
// tb_slurm16_cpu_scoreboard: directed and random stimulus against a queue-based reference model.
module tb_slurm16_cpu_scoreboard;
    localparam int DEPTH = 4;
`ifdef SLURM16_SCOREBOARD_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic CLK = 1'b0;
    logic RST = 1'b1;
    logic issue_valid = 1'b0;
    logic [3:0] regA_sel = '0;
    logic [3:0] regB_sel = '0;
    logic dest_we = 1'b0;
    logic [3:0] dest_sel = '0;
    logic is_load = 1'b0;
    logic flush = 1'b0;
    logic mem_ack_valid = 1'b0;
    logic stall;
    logic [15:0] pending;
    logic [2:0] load_count;
    logic ack_underflow;

    slurm16_cpu_scoreboard #(.REGISTER_BITS(4), .LOAD_DEPTH(DEPTH)) dut (
        .CLK(CLK),
        .RST(RST),
        .issue_valid(issue_valid),
        .regA_sel(regA_sel),
        .regB_sel(regB_sel),
        .dest_we(dest_we),
        .dest_sel(dest_sel),
        .is_load(is_load),
        .flush(flush),
        .mem_ack_valid(mem_ack_valid),
        .stall(stall),
        .pending(pending),
        .load_count(load_count),
        .ack_underflow(ack_underflow)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        bit stall;
        logic [15:0] pend;
        int cnt;
        bit uf;
        int cycle;
    } expRec_t;

    expRec_t expQ[$];
    int tests = 0;
    int fails = 0;
    int cycle = 0;

    // Reference state: ALU dests in EX/MEM (0 = empty) and loads in program order.
    int exReg = 0;
    int memReg = 0;
    int loadQ[$];
    bit underflow = 0;

    function automatic bit inLoadQ(input int r);
        foreach (loadQ[i]) if (loadQ[i] == r) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [15:0] modelPending();
        logic [15:0] p = '0;
        if (exReg != 0) p[exReg] = 1'b1;
        if (memReg != 0) p[memReg] = 1'b1;
        foreach (loadQ[i]) p[loadQ[i]] = 1'b1;
        return p;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv, input int cyc);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, expv);
        end
    endtask

    task automatic drive(input bit rst, input bit iv, input int a, input int b, input bit we,
                         input int d, input bit ld, input bit fl, input bit ack);
        bit st, acc, rawHit, aluHit;
        int newMem;
        @(negedge CLK);
        cycle++;
        RST = rst;
        issue_valid = iv;
        regA_sel = 4'(a);
        regB_sel = 4'(b);
        dest_we = we;
        dest_sel = 4'(d);
        is_load = ld;
        flush = fl;
        mem_ack_valid = ack;
        if (rst) begin
            exReg = 0;
            memReg = 0;
            loadQ.delete();
            underflow = 0;
        end
        rawHit = (a != 0 && inLoadQ(a)) || (b != 0 && inLoadQ(b));
        aluHit = !FWD && ((a != 0 && (a == exReg || a == memReg)) || (b != 0 && (b == exReg || b == memReg)));
        st = iv && (rawHit || aluHit || (we && d != 0 && inLoadQ(d)) || (ld && loadQ.size() == DEPTH && !ack));
        expQ.push_back('{st, modelPending(), loadQ.size(), underflow, cycle});
        if (!rst) begin
            acc = iv && !st && !fl;
            if (ack) begin
                if (loadQ.size() > 0) void'(loadQ.pop_front());
                else underflow = 1'b1;
            end
            newMem = fl ? 0 : exReg;
            exReg = (acc && we && !ld && d != 0) ? d : 0;
            memReg = newMem;
            if (acc && we && ld && d != 0) loadQ.push_back(d);
        end
    endtask

    task automatic op(input bit iv, input int a, input int b, input bit we, input int d,
                      input bit ld, input bit fl, input bit ack);
        drive(1'b0, iv, a, b, we, d, ld, fl, ack);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) op(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    function automatic int randReg();
        return $urandom_range(0, 1) ? int'($urandom_range(0, 7)) : int'($urandom_range(0, 15));
    endfunction

    // Monitor: the outputs observed each cycle are compared with the oldest expectation.
    initial begin
        expRec_t r;
        forever begin
            @(negedge CLK);
            #2;
            if (expQ.size() != 0) begin
                r = expQ.pop_front();
                check("stall", 32'(stall), 32'(r.stall), r.cycle);
                check("pending", 32'(pending), 32'(r.pend), r.cycle);
                check("load_count", 32'(load_count), r.cnt, r.cycle);
                check("ack_underflow", 32'(ack_underflow), 32'(r.uf), r.cycle);
            end
        end
    end

    initial begin
        drive(1'b1, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(2);
        // ALU r3 followed by a reader of r3
        op(1, 0, 0, 1, 3, 0, 0, 0);
        op(1, 3, 0, 0, 0, 0, 0, 0);
        op(1, 3, 0, 0, 0, 0, 0, 0);
        op(1, 3, 0, 0, 0, 0, 0, 0);
        idle(3);
        // load r5, reader waits, ack on the third cycle
        op(1, 0, 0, 1, 5, 1, 0, 0);
        op(1, 0, 5, 0, 0, 0, 0, 0);
        op(1, 0, 5, 0, 0, 0, 0, 0);
        op(1, 0, 5, 0, 0, 0, 0, 1);
        op(1, 0, 5, 0, 0, 0, 0, 0);
        idle(2);
        // fill the queue, fifth load issues alongside an ack
        for (int r = 1; r <= 4; r++) op(1, 0, 0, 1, r, 1, 0, 0);
        op(1, 0, 0, 1, 6, 1, 0, 0);
        op(1, 0, 0, 1, 6, 1, 0, 1);
        for (int i = 0; i < 5; i++) op(0, 0, 0, 0, 0, 0, 0, 1);
        idle(1);
        // load r7 then ALU write r7 (WAW), plus an r0 write
        op(1, 0, 0, 1, 7, 1, 0, 0);
        op(1, 0, 0, 1, 7, 0, 0, 0);
        op(1, 0, 0, 1, 7, 0, 0, 1);
        op(1, 0, 0, 1, 7, 0, 0, 0);
        op(1, 0, 0, 1, 0, 0, 0, 0);
        idle(3);
        // flush kills EX (r2) while MEM (r4) and queued load (r9) survive
        op(1, 0, 0, 1, 9, 1, 0, 0);
        op(1, 0, 0, 1, 4, 0, 0, 0);
        op(1, 0, 0, 1, 2, 0, 0, 0);
        op(1, 0, 0, 1, 11, 0, 1, 0);
        idle(2);
        op(0, 0, 0, 0, 0, 0, 0, 1);
        idle(2);
        drive(1'b1, 0, 0, 0, 0, 0, 0, 0, 0);
        // random phase with periodic mid-operation resets
        for (int n = 0; n < 1500; n++) begin
            if (n % 250 == 249) drive(1'b1, 0, 0, 0, 0, 0, 0, 0, 0);
            else op($urandom_range(0, 3) != 0, randReg(), randReg(), $urandom_range(0, 4) != 0,
                    randReg(), $urandom_range(0, 2) == 0, $urandom_range(0, 9) == 0,
                    $urandom_range(0, 3) == 0);
        end
        idle(2);
        @(negedge CLK);
        #3;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/slurm16_cpu_scoreboard.md
# slurm16_cpu_scoreboard

Register scoreboard and issue interlock for the slurm16 pipeline. Tracks every register with an outstanding write: ALU results in flight through EX/MEM, and loads waiting on the memory port in an in-order load queue. Compares the decoder's register selects against that state and holds issue (`stall`) until operands and destination are safe. Sits between the stage-1 instruction decoder and the issue/register-read stage; memory acknowledgements retire queued loads.

## Interface

Parameters:
- `REGISTER_BITS`, 4: register select width (16 registers).
- `LOAD_DEPTH`, 4: load queue entries (power of two, 2..8).

Ports:
- `CLK`  in  1  clock, all state on rising edge.
- `RST`  in  1  asynchronous, active-high reset.
- `issue_valid`  in  1  decoded instruction requests issue this cycle.
- `regA_sel`  in  REGISTER_BITS  source A from decoder.
- `regB_sel`  in  REGISTER_BITS  source B from decoder.
- `dest_we`  in  1  instruction writes a register.
- `dest_sel`  in  REGISTER_BITS  destination register.
- `is_load`  in  1  destination written by memory, not the ALU.
- `flush`  in  1  kill the EX slot (taken branch).
- `mem_ack_valid`  in  1  oldest outstanding load has completed; its register is written this cycle.
- `stall`  out  1  issue blocked; combinational.
- `pending`  out  16  per-register outstanding-write bitmap; registered.
- `load_count`  out  $clog2(LOAD_DEPTH)+1  queue occupancy.
- `ack_underflow`  out  1  sticky error flag.

## Operation

- Issue is accepted when `issue_valid && !stall`.
- Accepted with `dest_we && !is_load && dest_sel!=0`: dest enters the EX slot.
- Accepted with `dest_we && is_load && dest_sel!=0`: dest pushed to the load queue tail.
- Register 0 is never pending. Sources or dest equal to 0 never stall.
- ALU pipe: EX -> MEM -> WB each cycle. WB writes the register file write-through, so a WB match never stalls.
- `stall` asserts if any of these holds:
  - (a) regA_sel or regB_sel (nonzero) matches any valid queue entry.
  - (b) regA_sel or regB_sel matches the EX or MEM dest. This term is removed when SLURM16_SCOREBOARD_FWD_EN is defined.
  - (c) a writing instruction's dest_sel matches any queue entry (WAW).
  - (d) is_load with the queue full and `!mem_ack_valid`.
- ALU-vs-ALU dest matches never stall; the pipe is in order.
- `mem_ack_valid` pops the queue head on the edge. A match against the head stalls through the ack cycle and releases the following cycle.
- Push and pop in the same cycle are legal at any occupancy, including full. Occupancy is then unchanged.
- `mem_ack_valid` with an empty queue is ignored and sets `ack_underflow`, which holds until reset.
- `flush` invalidates the EX slot on the edge. In the same cycle it forces acceptance off, so any instruction presented that cycle is not entered. Both EX and queue are untouched by that instruction. MEM and the load queue are never flushed; issued loads always complete.
- `pending` = OR of the one-hot EX, MEM and valid queue dests. It is registered, so it reflects post-edge state.

## Timing

- Reset, asynchronous: EX/MEM invalid, queue empty with pointers at 0, `pending`=0, `load_count`=0, `ack_underflow`=0. `stall` follows its inputs and is 0 with `issue_valid`=0.
- Reset mid-operation discards all in-flight tracking. Memory must not ack pre-reset loads.
- ALU op accepted at t: EX at t+1, MEM at t+2, WB at t+3.
  - Without FWD, a dependent instruction issues no earlier than t+3.
  - With FWD, it issues at t+1.
- Load accepted at t: pending from t+1. Ack at cycle a clears it at a+1, and a dependent instruction issues at a+1.
- Queue pointers wrap modulo LOAD_DEPTH. Full/empty are distinguished by `load_count`.

## Configuration

- `SLURM16_SCOREBOARD_FWD_EN` defined:
  - EX and MEM ALU results are bypassed; term (b) is removed.
  - The EX/MEM slots still feed `pending`.
- Undefined: term (b) is active.
- Load stalls and WAW stalls are identical in both builds.

## Structure

- Shared package `slurm16_cpu_pkg` holds:
  - the register count;
  - `LOAD_DEPTH_DEFAULT`;
  - the one-hot decode function used for `pending`.
- One sub-module: `slurm16_load_tag_fifo`.
  - Circular dest-tag queue with per-entry valid bits and simultaneous push/pop.
  - Exposes its entries for parallel match.
- Match logic, ALU slots and the stall equation live in the top.

## Test plan

- ALU `r3` issued at t, then a reader of `r3` presented at t+1:
  - without FWD: `stall`=1 at t+1 and t+2, issues at t+3;
  - with FWD: no stall.
- Load to `r5`, ack at a, reader of `r5` waiting: `stall`=1 through a, 0 at a+1. `pending[5]` is 1 from t+1 and 0 at a+1.
- Four loads to r1..r4 fill the queue (`load_count`=4). A fifth load stalls, and issues in the cycle `mem_ack_valid`=1 with `load_count` staying 4. Pops then occur in order r1, r2, r3, r4.
- Load to `r7` pending, then an ALU write to `r7`: `stall`=1 until the cycle after the ack. An ALU write to `r0` never stalls and `pending[0]` stays 0.
- `flush` with ALU `r2` in EX: `pending[2]` drops next edge, and the MEM occupant and queued loads are unaffected. Ack on an empty queue sets `ack_underflow`=1 until `RST`.
